// File: rtl/alu_result_bcd_conv.sv
// ---------------------------------------------------------------------------
// alu_result_bcd_conv
//
// Takes one result from the calculator's 8-bit ALU and turns it into packed
// BCD digits for the display driver. Add/sub results already arrive in BCD
// and pass straight through. Binary mul/div results go through a double-dabble
// engine that processes one source bit per clock.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   start      capture op/result/status (ignored while busy)
//   op         00=add, 01=sub, 10=mul, 11=div
//   result     16-bit ALU result word
//   status     carry / borrow / overflow / div0 flag from the ALU
//   busy       high while a binary-to-BCD conversion is running
//   done       one-cycle pulse when digits/rem_digits/neg/err are valid
//   digits     five packed BCD digits, [19:16] is the most significant
//   rem_digits three packed BCD digits of the division remainder
//   neg        subtraction result is negative
//   err        division by zero
// ---------------------------------------------------------------------------
module alu_result_bcd_conv #(
    parameter logic [3:0] ERR_NIBBLE = 4'hE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] result,
    input  logic        status,
    output logic        busy,
    output logic        done,
    output logic [19:0] digits,
    output logic [11:0] rem_digits,
    output logic        neg,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        CONV_Q,
        CONV_R
    } state_t;

    state_t      state;

    // {bcd[19:0], bin[15:0]}: the binary source is left-aligned in the low
    // half so that its MSB is always shifted out first, whatever its width.
    logic [35:0] shreg;
    logic [4:0]  count;
    logic        is_div;
    logic [7:0]  rem_src;
    logic [35:0] dab;

    // One double-dabble step: correct every BCD digit >= 5, then shift the
    // whole register left so the next binary bit enters the BCD field.
    function automatic logic [35:0] dabble_step(input logic [35:0] v);
        logic [35:0] t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            if (t[16 + 4*i +: 4] >= 4'd5)
                t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction

    assign dab = dabble_step(shreg);

    // Single FSM with registered outputs. Add/sub/div0 complete straight from
    // IDLE; mul runs 16 steps in CONV_Q, div runs 8 quotient steps in CONV_Q
    // followed by 8 remainder steps in CONV_R.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            count      <= '0;
            is_div     <= 1'b0;
            rem_src    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            digits     <= '0;
            rem_digits <= '0;
            neg        <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg        <= 1'b0;
                        err        <= 1'b0;
                        rem_digits <= '0;
                        case (op)
                            2'b01: begin
                                digits <= {12'h000, result[7:0]};
                                neg    <= status;
                                done   <= 1'b1;
                            end
                            2'b10: begin
                                shreg  <= {20'h00000, result};
                                count  <= 5'd16;
                                is_div <= 1'b0;
                                busy   <= 1'b1;
                                state  <= CONV_Q;
                            end
                            2'b11: begin
                                if (status) begin
                                    digits <= {5{ERR_NIBBLE}};
                                    err    <= 1'b1;
                                    done   <= 1'b1;
                                end else begin
                                    shreg   <= {20'h00000, result[7:0], 8'h00};
                                    count   <= 5'd8;
                                    is_div  <= 1'b1;
                                    rem_src <= result[15:8];
                                    busy    <= 1'b1;
                                    state   <= CONV_Q;
                                end
                            end
                            default: begin
                                // Add: d2 carries the ALU carry, d1..d0 the BCD sum.
                                digits <= {8'h00, 3'b000, status, result[7:0]};
                                done   <= 1'b1;
                            end
                        endcase
                    end
                end

                CONV_Q: begin
                    shreg <= dab;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        if (is_div) begin
                            // Quotient is at most 255, so only three digits matter.
                            digits <= {8'h00, dab[27:16]};
                            shreg  <= {20'h00000, rem_src, 8'h00};
                            count  <= 5'd8;
                            state  <= CONV_R;
                        end else begin
                            digits <= dab[35:16];
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end

                CONV_R: begin
                    shreg <= dab;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        rem_digits <= dab[27:16];
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_alu_result_bcd_conv
//
// Directed vectors with hand-computed BCD results. The stimulus side pushes
// the expected response into a queue; an independent monitor pops and
// compares it whenever done is seen. Latency is expressed as the number of
// busy cycles observed before the done pulse.
// ---------------------------------------------------------------------------
module tb_alu_result_bcd_conv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] result;
    logic        status;
    logic        busy;
    logic        done;
    logic [19:0] digits;
    logic [11:0] rem_digits;
    logic        neg;
    logic        err;

    typedef struct {
        logic [19:0] digits;
        logic [11:0] rem_digits;
        logic        neg;
        logic        err;
        int          busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;
    int   busy_cnt;

    alu_result_bcd_conv #(.ERR_NIBBLE(4'hE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .result     (result),
        .status     (status),
        .busy       (busy),
        .done       (done),
        .digits     (digits),
        .rem_digits (rem_digits),
        .neg        (neg),
        .err        (err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic compare; every call is one counted comparison.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one start pulse; called at a negedge, returns at the next negedge.
    task automatic applyStimulus(input logic [1:0] o, input logic [15:0] r,
                                 input logic s, input logic [19:0] e_dig,
                                 input logic [11:0] e_rem, input logic e_neg,
                                 input logic e_err, input int e_lat);
        exp_t e;
        e.digits      = e_dig;
        e.rem_digits  = e_rem;
        e.neg         = e_neg;
        e.err         = e_err;
        e.busy_cycles = e_lat;
        sb.push_back(e);
        op     = o;
        result = r;
        status = s;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Bounded wait until the scoreboard has drained.
    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL timeout: %0d responses still pending", sb.size());
            sb.delete();
        end
    endtask

    // Bounded wait for a done pulse, returning at the negedge that sees it.
    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL done_timeout: done=%0b, expected 1", done);
        end
    endtask

    // Monitor: samples at the falling edge, away from the active edge.
    initial begin
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_done: got done with digits=0x%0h, expected no done",
                             digits);
                end else begin
                    e = sb.pop_front();
                    checkOutput("digits", {12'h0, digits}, {12'h0, e.digits});
                    checkOutput("rem_digits", {20'h0, rem_digits}, {20'h0, e.rem_digits});
                    checkOutput("neg", {31'h0, neg}, {31'h0, e.neg});
                    checkOutput("err", {31'h0, err}, {31'h0, e.err});
                    checkOutput("busy_cycles", busy_cnt, e.busy_cycles);
                end
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        start  = 1'b0;
        op     = 2'b00;
        result = 16'h0000;
        status = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_done", {31'h0, done}, 32'h0);
        checkOutput("reset_digits", {12'h0, digits}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // add / sub / div0: immediate completion, no busy cycles
        applyStimulus(2'b00, 16'h0012, 1'b1, 20'h00112, 12'h000, 1'b0, 1'b0, 0);
        waitDrain(40);
        applyStimulus(2'b01, 16'h0019, 1'b1, 20'h00019, 12'h000, 1'b1, 1'b0, 0);
        waitDrain(40);
        applyStimulus(2'b01, 16'h0042, 1'b0, 20'h00042, 12'h000, 1'b0, 1'b0, 0);
        waitDrain(40);
        applyStimulus(2'b00, 16'h0099, 1'b0, 20'h00099, 12'h000, 1'b0, 1'b0, 0);
        waitDrain(40);

        // mul: 255*255 = 65025 and 0
        applyStimulus(2'b10, 16'hFE01, 1'b1, 20'h65025, 12'h000, 1'b0, 1'b0, 16);
        waitDrain(40);
        applyStimulus(2'b10, 16'h0000, 1'b0, 20'h00000, 12'h000, 1'b0, 1'b0, 16);
        waitDrain(40);

        // div: 200/7 = 28 r 4, and the 255 r 255 extreme
        applyStimulus(2'b11, 16'h041C, 1'b0, 20'h00028, 12'h004, 1'b0, 1'b0, 16);
        waitDrain(40);
        applyStimulus(2'b11, 16'hFFFF, 1'b0, 20'h00255, 12'h255, 1'b0, 1'b0, 16);
        waitDrain(40);

        // div0
        applyStimulus(2'b11, 16'hFFFF, 1'b1, 20'hEEEEE, 12'h000, 1'b0, 1'b1, 0);
        waitDrain(40);

        // mul 12345 with a stray start during the conversion; also shows err
        // and rem_digits cleared by the accepted start
        applyStimulus(2'b10, 16'h3039, 1'b0, 20'h12345, 12'h000, 1'b0, 1'b0, 16);
        repeat (4) @(negedge clk);
        op     = 2'b00;
        result = 16'h0001;
        status = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waitDrain(40);

        // New start on the done cycle is accepted
        applyStimulus(2'b10, 16'h0063, 1'b0, 20'h00099, 12'h000, 1'b0, 1'b0, 16);
        waitDone(40);
        applyStimulus(2'b00, 16'h0045, 1'b0, 20'h00045, 12'h000, 1'b0, 1'b0, 0);
        waitDrain(40);

        // Reset in the middle of a mul: outputs drop at once, no done follows
        applyStimulus(2'b10, 16'hFE01, 1'b1, 20'h65025, 12'h000, 1'b0, 1'b0, 16);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("abort_digits", {12'h0, digits}, 32'h0);
        checkOutput("abort_done", {31'h0, done}, 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (24) @(negedge clk);
        checkOutput("abort_idle_busy", {31'h0, busy}, 32'h0);

        // Engine still works after the abort
        applyStimulus(2'b11, 16'h041C, 1'b0, 20'h00028, 12'h004, 1'b0, 1'b0, 16);
        waitDrain(40);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
